// File: rtl/mips_defs.sv
// Shared MIPS multicycle definitions: controller state encodings, opcodes,
// ALU operation classes and datapath mux selects.
package mips_defs;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BEQ    = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_e;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // ALU decoder classes, also consumed by the datapath ALU decoder.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    function automatic logic op_supported(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/multicycle_control.sv
// Moore control FSM for the multicycle MIPS datapath: one state register,
// combinational next-state and per-state datapath controls.
module multicycle_control
    import mips_defs::*;
#(
    parameter logic MEM_HANDSHAKE = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       branch,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       memto_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic [3:0] state,
    output logic       illegal
);

    state_e state_q, state_d;
    logic   ready;

    assign ready = MEM_HANDSHAKE ? mem_ready : 1'b1;
    assign state = state_q;

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values of its inputs, independent of process ordering.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_d = ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            default:  state_d = S_FETCH;
        endcase
    end

    // Controls are forced inactive while reset is high, even mid-instruction.
    always_comb begin
        pc_write  = 1'b0;
        branch    = 1'b0;
        iord      = 1'b0;
        mem_write = 1'b0;
        ir_write  = 1'b0;
        reg_dst   = 1'b0;
        memto_reg = 1'b0;
        reg_write = 1'b0;
        alu_src_a = 1'b0;
        alu_src_b = SRCB_REG;
        alu_op    = ALUOP_ADD;
        pc_src    = PCSRC_ALU;
        illegal   = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    alu_src_b = SRCB_FOUR;
                    ir_write  = ready;
                    pc_write  = ready;
                end
                S_DECODE: begin
                    alu_src_b = SRCB_IMM_SH;
                    illegal   = !op_supported(opcode);
                end
                S_MEMADR, S_ADDIEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                end
                S_MEMRD:  iord = 1'b1;
                S_MEMWB: begin
                    reg_write = 1'b1;
                    memto_reg = 1'b1;
                end
                S_MEMWR: begin
                    iord      = 1'b1;
                    mem_write = 1'b1;
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALUOP_FUNCT;
                end
                S_ALUWB: begin
                    reg_dst   = 1'b1;
                    reg_write = 1'b1;
                end
                S_BEQ: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALUOP_SUB;
                    pc_src    = PCSRC_ALUOUT;
                    branch    = 1'b1;
                end
                S_ADDIWB: reg_write = 1'b1;
                S_JUMP: begin
                    pc_src   = PCSRC_JUMP;
                    pc_write = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter MEM_HANDSHAKE, default 1: 1 = memory states wait for mem_ready; 0 = mem_ready is ignored and treated as 1.

Ports (name, direction, width, meaning):
REQ-002 The block SHALL have port clk, input, 1: the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 The block SHALL have port opcode, input, 6: Instr[31:26] from the instruction register.
REQ-005 The block SHALL have port mem_ready, input, 1: memory access completes in the current cycle.
REQ-006 The block SHALL have output ports pc_write (1), branch (1), iord (1), mem_write (1), ir_write (1), reg_dst (1), memto_reg (1), reg_write (1), alu_src_a (1): datapath enables and selects.
REQ-007 The block SHALL have output ports alu_src_b (2), alu_op (2), pc_src (2): datapath mux selects and ALU-decoder class.
REQ-008 The block SHALL have output port state, 4 bits: current state encoding, for debug display.
REQ-009 The block SHALL have output port illegal, 1 bit: one-cycle pulse in DECODE when the opcode is unsupported.

Function
REQ-010 The block SHALL be a Moore FSM with states FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BEQ=8, ADDIEX=9, ADDIWB=10, JUMP=11; encodings 12-15 SHALL go to FETCH on the next edge.
REQ-011 The block SHALL decode opcodes as: lw 100011, sw 101011, R-type 000000, beq 000100, addi 001000, j 000010.
REQ-012 The block SHALL make these transitions:
- FETCH->DECODE when ready, else stay in FETCH.
- DECODE->MEMADR (lw/sw), EXEC (R-type), BEQ, ADDIEX, JUMP; any other opcode goes to FETCH with illegal=1.
- MEMADR->MEMRD (lw) or MEMWR (sw).
- MEMRD->MEMWB when ready, else stay.
- MEMWR->FETCH when ready, else stay.
- MEMWB, ALUWB, BEQ, ADDIWB, JUMP->FETCH; EXEC->ALUWB; ADDIEX->ADDIWB.
REQ-013 The block SHALL drive these outputs per state (unlisted outputs 0):
- FETCH: alu_src_b=01, ir_write and pc_write = ready.
- DECODE: alu_src_b=11.
- MEMADR, ADDIEX: alu_src_a=1, alu_src_b=10.
- MEMRD: iord=1.
- MEMWB: reg_write=1, memto_reg=1.
- MEMWR: iord=1, mem_write=1.
- EXEC: alu_src_a=1, alu_op=10.
- ALUWB: reg_dst=1, reg_write=1.
- BEQ: alu_src_a=1, alu_op=01, pc_src=01, branch=1.
- ADDIWB: reg_write=1.
- JUMP: pc_src=10, pc_write=1.
REQ-014 ready SHALL equal mem_ready when MEM_HANDSHAKE=1 and SHALL be constant 1 otherwise.
REQ-015 mem_write SHALL stay asserted for every cycle spent in MEMWR, including wait cycles.
REQ-016 The block SHALL give each instruction this latency with ready=1: lw 5 cycles, sw 4, R-type 4, addi 4, beq 3, j 3; every wait cycle SHALL add exactly one cycle.
REQ-017 opcode SHALL be sampled only in DECODE and MEMADR; changes in any other state SHALL have no effect.

Reset
REQ-018 The block SHALL load state FETCH on a clock edge with reset=1, and reset SHALL override every transition, including one taken mid-instruction or during a wait.
REQ-019 The block SHALL force pc_write, ir_write, mem_write, reg_write and illegal to 0 while reset=1, and all selects to 0.
REQ-020 The first fetch SHALL occur in the first cycle after reset deasserts.

Structure
REQ-021 The state encodings, the opcode constants and the alu_op codes (00 add, 01 sub, 10 funct) SHALL live in a shared package/include (mips_defs) that the datapath ALU decoder also uses.
REQ-022 The block SHALL use a single state register with combinational next-state and output logic; no sub-module is needed, and the ALU decoder SHALL stay a separate existing block.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Reset for 2 cycles, then release with mem_ready=1 -> state=0, pc_write=1 and ir_write=1 in the first cycle, and all enables were 0 during reset.
- opcode=100011, mem_ready=1 -> states 0,1,2,3,4; reg_write=1 and memto_reg=1 only in state 4.
- opcode=101011, mem_ready low for 2 cycles in MEMWR -> state 5 held 3 cycles, mem_write=1 throughout, then state=0.
- opcode=000100 -> states 0,1,8 with branch=1, pc_src=01 and alu_op=01 in state 8; opcode=000010 -> state 11 with pc_write=1 and pc_src=10.
- opcode=111111 -> illegal=1 for one cycle in DECODE, then state=0 with no write enable asserted.
- Reset asserted while in EXEC (state 6) -> state=0 on the next edge and ALUWB never entered; with MEM_HANDSHAKE=0 and mem_ready=0, lw still completes in 5 cycles.
